// File: rtl/taylor_series_cos_pkg.sv
// Shared definitions for the fixed-point Taylor-series cosine unit.
//   W       : I/O word width (angle_in / cos_out are unsigned Q2.16)
//   FRAC_IO : fractional bits of the I/O words
//   FRAC_C  : fractional bits of coefficients and accumulator
//   ACC_W   : signed width of the accumulator and MAC operands
//   C[0:4]  : Taylor coefficients of cos(x) in x^2, signed Q.24, rounded
package taylor_pkg;

  localparam int unsigned W       = 18;
  localparam int unsigned FRAC_IO = 16;
  localparam int unsigned FRAC_C  = 24;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned PROD_W  = 2 * ACC_W;
  localparam int signed   ONE_IO  = 65536;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    H1,
    H2,
    H3,
    H4,
    DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] C [0:4] = '{
    32'sd16777216,  //  1
    -32'sd8388608,  // -1/2
    32'sd699051,    //  1/24
    -32'sd23302,    // -1/720
    32'sd416        //  1/40320
  };

endpackage

// File: rtl/taylor_series_cos_mac.sv
// taylor_mac: combinational signed multiply, arithmetic right shift, add.
//   i_a, i_b : signed ACC_W-bit operands
//   i_shift  : arithmetic right-shift amount applied to the full product
//   i_coef   : signed addend
//   o_res    : i_coef + ((i_a * i_b) >>> i_shift), truncated to ACC_W bits
module taylor_mac
  import taylor_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  input  logic        [5:0]       i_shift,
  input  logic signed [ACC_W-1:0] i_coef,
  output logic signed [ACC_W-1:0] o_res
);

  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shifted;

  // Explicit sign extension keeps the product exact at full width.
  assign w_a_ext   = $signed({{(PROD_W-ACC_W){i_a[ACC_W-1]}}, i_a});
  assign w_b_ext   = $signed({{(PROD_W-ACC_W){i_b[ACC_W-1]}}, i_b});
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_shifted = w_prod >>> i_shift;
  assign o_res     = $signed(w_shifted[ACC_W-1:0]) + i_coef;

endmodule

// File: rtl/taylor_series_cos.sv
// taylor_series_cos: sequential cos(x) via Horner evaluation on x^2.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high reset
//   start     : request; accepted only in IDLE or in DONE once ready_out is up
//   angle_in  : unsigned Q2.16 angle in radians
//   ready_out : result valid; holds until the next accepted start
//   cos_out   : unsigned Q2.16 cosine, clamped to [0, 1.0]
// Start sampled at edge k gives ready_out/cos_out valid after edge k+6.
module taylor_series_cos
  import taylor_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  output logic         ready_out,
  output logic [W-1:0] cos_out
);

  state_t r_state;
  state_t w_next;

  logic        [W-1:0]     r_x;
  logic signed [ACC_W-1:0] r_x2;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ready;
  logic        [W-1:0]     r_cos;

  logic signed [ACC_W-1:0] w_mac_a;
  logic signed [ACC_W-1:0] w_mac_b;
  logic        [5:0]       w_mac_shift;
  logic signed [ACC_W-1:0] w_mac_coef;
  logic signed [ACC_W-1:0] w_mac_res;
  logic signed [ACC_W-1:0] w_round;
  logic        [W-1:0]     w_clamped;
  logic signed [ACC_W-1:0] w_x_ext;

  localparam logic [5:0] SQ_SHIFT = 6'(2 * FRAC_IO - FRAC_C);
  localparam logic [5:0] HN_SHIFT = 6'(FRAC_C);
  localparam int unsigned RND_SH  = FRAC_C - FRAC_IO;

  assign w_x_ext = $signed({{(ACC_W-W){1'b0}}, r_x});

  taylor_mac u_mac (
    .i_a     (w_mac_a),
    .i_b     (w_mac_b),
    .i_shift (w_mac_shift),
    .i_coef  (w_mac_coef),
    .o_res   (w_mac_res)
  );

  // One MAC serves both the squaring step and the four Horner steps.
  always_comb begin
    w_mac_a     = r_acc;
    w_mac_b     = r_x2;
    w_mac_shift = HN_SHIFT;
    w_mac_coef  = '0;
    case (r_state)
      SQUARE: begin
        w_mac_a     = w_x_ext;
        w_mac_b     = w_x_ext;
        w_mac_shift = SQ_SHIFT;
        w_mac_coef  = '0;
      end
      H1:      w_mac_coef = C[3];
      H2:      w_mac_coef = C[2];
      H3:      w_mac_coef = C[1];
      H4:      w_mac_coef = C[0];
      default: w_mac_coef = '0;
    endcase
  end

  // Round Q.24 accumulator to Q.16, then clamp into [0, 1.0].
  always_comb begin
    w_round   = (r_acc + (ACC_W'(1) <<< (RND_SH - 1))) >>> RND_SH;
    w_clamped = '0;
    if (w_round < 0)
      w_clamped = '0;
    else if (w_round > ONE_IO)
      w_clamped = W'(ONE_IO);
    else
      w_clamped = w_round[W-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SQUARE;
      SQUARE:  w_next = H1;
      H1:      w_next = H2;
      H2:      w_next = H3;
      H3:      w_next = H4;
      H4:      w_next = DONE;
      // First DONE cycle registers the result; starts are taken once it is shown.
      DONE:    if (r_ready && start) w_next = SQUARE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_x2    <= '0;
      r_acc   <= '0;
      r_ready <= 1'b0;
      r_cos   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= angle_in;
            r_ready <= 1'b0;
          end
        end
        SQUARE: begin
          r_x2  <= w_mac_res;
          r_acc <= C[4];
        end
        H1, H2, H3, H4: r_acc <= w_mac_res;
        DONE: begin
          if (!r_ready) begin
            r_cos   <= w_clamped;
            r_ready <= 1'b1;
          end else if (start) begin
            r_x     <= angle_in;
            r_ready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out = r_ready;
  assign cos_out   = r_cos;

endmodule

// File: tb/tb_taylor_series_cos.sv
module tb_taylor_series_cos;

  logic        clock;
  logic        reset;
  logic        start;
  logic [17:0] angle_in;
  logic        ready_out;
  logic [17:0] cos_out;

  int n_checks;
  int n_errors;

  taylor_series_cos dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .angle_in  (angle_in),
    .ready_out (ready_out),
    .cos_out   (cos_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint got, input longint exp,
                     input longint tol);
    longint d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // Reference: real-valued cosine of the Q2.16 angle, rounded and floored at 0.
  function automatic int ref_cos(input int a);
    real c;
    c = $cos(real'(a) / 65536.0) * 65536.0;
    if (c < 0.0) return 0;
    return $rtoi(c + 0.5);
  endfunction

  // Launch one request: start held plen cycles; if disturb, angle/start are
  // scrambled during the busy edges. Returns cycles to ready_out and result.
  task automatic launch(input int a, input int plen, input bit disturb,
                        output int lat, output int res);
    angle_in = 18'(a);
    start    = 1'b1;
    @(posedge clock); #1;
    chk("rdy_clr", longint'(ready_out), 0, 0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (disturb && n <= 5) begin
        start    = 1'($urandom);
        angle_in = 18'($urandom);
      end else if (n >= plen) begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      if (ready_out) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    res   = int'(cos_out);
    if (lat < 0) chk("timeout", 0, 1, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int lat, res, prev, err, sum_err, npts, held;
    int dir_a [4];
    int dir_e [4];
    n_checks = 0;
    n_errors = 0;
    start    = 1'b0;
    angle_in = '0;
    reset    = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_ready", longint'(ready_out), 0, 0);
    chk("rst_cos", longint'(cos_out), 0, 0);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (ready_out) held++;
    end
    chk("idle_no_ready", held, 0, 0);

    // Zero angle with a 2-cycle start pulse; exactly one completion.
    launch(0, 2, 1'b0, lat, res);
    chk("lat_zero", lat, 6, 0);
    chk("cos_zero", res, 65536, 3);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (ready_out && int'(cos_out) == res) held++;
    end
    chk("single_done", held, 10, 0);

    // Directed points.
    dir_a = '{64, 51472, 68629, 102912};
    dir_e = '{65536, 46341, 32768, 32};
    foreach (dir_a[i]) begin
      launch(dir_a[i], 1, 1'b0, lat, res);
      chk("lat_dir", lat, 6, 0);
      chk("cos_dir", res, dir_e[i], 3);
      idle_cycles(2);
    end

    // Sweep with monotonicity and mean-error tracking.
    prev = 65536 + 1;
    sum_err = 0;
    npts = 0;
    for (int a = 64; a <= 102912; a += 64) begin
      launch(a, 1, 1'b0, lat, res);
      chk("lat_sweep", lat, 6, 0);
      chk("cos_sweep", res, ref_cos(a), 3);
      chk("mono", (res > prev + 1) ? 1 : 0, 0, 0);
      prev = res;
      err = res - ref_cos(a);
      sum_err += (err < 0) ? -err : err;
      npts++;
      idle_cycles(5);
    end
    chk("mean_err", sum_err, 0, npts);

    // Random angles, random pulse lengths, some with busy-time disturbance.
    for (int i = 0; i < 60; i++) begin
      int a;
      bit dis;
      a   = int'($urandom_range(0, 102944));
      dis = 1'($urandom);
      launch(a, int'($urandom_range(1, 4)), dis, lat, res);
      chk(dis ? "lat_dist" : "lat_rand", lat, 6, 0);
      chk(dis ? "cos_dist" : "cos_rand", res, ref_cos(a), 3);
      idle_cycles(int'($urandom_range(0, 5)));
    end

    // Back-to-back: new start in the same cycle ready_out is high.
    launch(51472, 1, 1'b0, lat, res);
    launch(0, 1, 1'b0, lat, res);
    chk("lat_b2b", lat, 6, 0);
    chk("cos_b2b", res, 65536, 3);
    idle_cycles(2);

    // Reset during H2 aborts the computation.
    angle_in = 18'd51472;
    start    = 1'b1;
    @(posedge clock); #1;   // latched, now SQUARE
    start = 1'b0;
    @(posedge clock); #1;   // H1
    @(posedge clock); #1;   // H2
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_ready", longint'(ready_out), 0, 0);
    chk("abort_cos", longint'(cos_out), 0, 0);
    held = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (ready_out) held++;
    end
    chk("abort_no_ready", held, 0, 0);
    launch(68629, 1, 1'b0, lat, res);
    chk("lat_after_rst", lat, 6, 0);
    chk("cos_after_rst", res, 32768, 3);
    idle_cycles(2);

    // Maximum input: computed without wrap, clamped into [0, 65536].
    launch(262143, 1, 1'b0, lat, res);
    chk("lat_max", lat, 6, 0);
    chk("cos_max_range", res, 32768, 32768);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/taylor_series_cos.md
Name: taylor_series_cos

Overview:
- Sequential fixed-point cosine unit: on a start request it captures an unsigned angle in radians and evaluates cos(x) as a truncated Taylor series (terms through x^8/8!) using Horner's scheme on x^2.
- Reports completion with ready_out.
- Stand-alone datapath block, driven by a controller or testbench that sweeps angles over [0, π/2].

Parameters:
- W, 18, I/O word width; angle_in and cos_out are unsigned Q2.16 (value = code / 65536).
- FRAC_IO, 16, fractional bits of angle_in and cos_out.
- FRAC_C, 24, fractional bits of the internal coefficients and accumulator.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while idle
- ready_out  out  1  result valid
- angle_in  in  W  angle, unsigned Q2.16 radians; valid range 0..102944 (π/2)
- cos_out  out  W  cos(angle), unsigned Q2.16; 65536 = 1.0

Behaviour:
Interface and reset:
- One clock; reset is synchronous and active-high.
- Reset: FSM to IDLE, ready_out=0, cos_out=0, internal registers cleared.
- Reset mid-computation aborts it; no ready_out follows.

FSM states: IDLE, SQUARE, H1, H2, H3, H4, DONE.
- IDLE or DONE with start=1 at edge k:
  - latch angle_in into x;
  - clear ready_out;
  - go to SQUARE.
- SQUARE: x2 = (x*x) >> (2*FRAC_IO - FRAC_C), giving x^2 in Q.24; computed at full width, no overflow for any 18-bit input.
- Horner steps, each one cycle, one multiply plus one add:
  - acc starts at C4;
  - acc = C(n-1) + ((acc*x2) >>> FRAC_C);
  - H1..H4 produce the acc for C3, C2, C1, C0 in turn.
- Coefficients, signed Q.24, rounded to nearest:
  - C0 = 1 → 16777216
  - C1 = -1/2 → -8388608
  - C2 = 1/24 → 699051
  - C3 = -1/720 → -23302
  - C4 = 1/40320 → 416
- Output conversion after H4: round acc to FRAC_IO bits (add 2^7, >>>8), then clamp to [0, 65536]; result registered into cos_out.
- DONE: ready_out=1.
  - Latency: start sampled at edge k → ready_out and cos_out valid after edge k+6.
  - ready_out and cos_out hold until the next accepted start; a new start is allowed in the same cycle ready_out is high.
- start is ignored in SQUARE..H4. A multi-cycle start pulse therefore launches exactly one computation, because latency > pulse length.
- cos_out changes only when entering DONE; it holds its old value during computation.
- Internal widths: signed, at least 2*(FRAC_C+4) bits for products. The accumulator must never wrap for any 18-bit input.
- Inputs above π/2 are computed and clamped; no accuracy requirement applies to them.
- Accuracy: |cos_out − round(65536·cos(angle_in/65536))| ≤ 3 LSB for every angle_in in 0..102944; mean error ≤ 1 LSB.

Decomposition:
- Package taylor_pkg:
  - W, FRAC_IO, FRAC_C;
  - the state enum;
  - coefficient constant array C[0:4];
  - ONE_IO = 65536.
- One natural sub-module: taylor_mac (signed multiply, arithmetic shift by FRAC_C, add coefficient). It is used for both SQUARE (with coefficient 0 and an adapted shift) and the Horner steps.
- FSM and output clamp live in the top module.

Test Plan:
- Reset held 1 cycle then released → ready_out=0, cos_out=0; start low for 5 cycles → no ready_out.
- angle_in=0, 2-cycle start pulse → ready_out rises exactly 6 cycles after the first start edge; cos_out=65536±3; only one completion occurs.
- angle_in=64, 51472 (π/4), 68629 (π/3), 102912 → cos_out ≈ 65536, 46341, 32768, 32 respectively (each ±3).
- Sweep angle_in from 64 to 102912 in steps of 64, starting a new request 5 cycles after each ready_out:
  - every result within ±3 LSB of the real-valued cosine;
  - cos_out is monotonically non-increasing within ±1;
  - mean error ≤ 1 LSB.
- angle_in changed and start toggled during SQUARE..H4 → ignored; result corresponds to the latched angle, with the original latency.
- reset asserted during H2 → next cycle IDLE, ready_out=0, cos_out=0; a fresh start afterwards completes normally.
- angle_in=262143 (max) → no wrap; cos_out clamped into [0, 65536].
